// File: rtl/lut_neuron_table_reader.sv
// Reader for a LUT neuron truth table: sweeps every input code, packs the
// responses into WORD_WIDTH-bit words and streams them out on valid/ready.
module lut_neuron_table_reader #(
    parameter int unsigned IN_BITS    = 8,
    parameter int unsigned OUT_BITS   = 2,
    parameter int unsigned WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [IN_BITS-1:0]    lut_addr_o,
    input  logic [OUT_BITS-1:0]   lut_data_i,
    output logic [WORD_WIDTH-1:0] m_tdata_o,
    output logic                  m_tvalid_o,
    input  logic                  m_tready_i,
    output logic                  m_tlast_o
);

    localparam int unsigned EPW   = WORD_WIDTH / OUT_BITS;
    localparam int unsigned SlotW = (EPW > 1) ? $clog2(EPW) : 1;
    localparam logic [IN_BITS-1:0] LastAddr = {IN_BITS{1'b1}};
    localparam logic [SlotW-1:0]   LastSlot = SlotW'(EPW - 1);

    typedef enum logic [1:0] {StIdle, StSweep, StDrain, StDone} state_e;

    state_e                state_q, state_d;
    logic [IN_BITS-1:0]    addr_q, addr_d;
    logic [SlotW-1:0]      slot_q, slot_d;
    logic [WORD_WIDTH-1:0] pack_q, pack_d;
    logic [WORD_WIDTH-1:0] tdata_q, tdata_d;
    logic                  tvalid_q, tvalid_d;
    logic                  tlast_q, tlast_d;
    logic                  done_q, done_d;

    logic [WORD_WIDTH-1:0] word;
    logic                  is_last, word_end, out_free, capture, load;

    // Current pack register with the live neuron response merged into its slot.
    always_comb begin
        word = pack_q;
        for (int k = 0; k < EPW; k++) begin
            if (slot_q == SlotW'(k)) begin
                word[k*OUT_BITS +: OUT_BITS] = lut_data_i;
            end
        end
    end

    // A word-completing capture waits until the output register can take it.
    always_comb begin
        is_last  = (addr_q == LastAddr);
        word_end = (slot_q == LastSlot) || is_last;
        out_free = !tvalid_q || m_tready_i;
        capture  = (state_q == StSweep) && (!word_end || out_free);
        load     = capture && word_end;
    end

    // Next-state logic for the sweep FSM, pack register and output register.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        slot_d   = slot_q;
        pack_d   = pack_q;
        done_d   = 1'b0;
        tdata_d  = tdata_q;
        tvalid_d = tvalid_q && !m_tready_i;
        tlast_d  = (tvalid_q && m_tready_i) ? 1'b0 : tlast_q;

        // A load may coincide with draining the previous word.
        if (load) begin
            tdata_d  = word;
            tvalid_d = 1'b1;
            tlast_d  = is_last;
        end

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StSweep;
                    addr_d  = '0;
                    slot_d  = '0;
                    pack_d  = '0;
                end
            end
            StSweep: begin
                if (capture) begin
                    // Wraps back to 0 after the last address.
                    addr_d = addr_q + 1'b1;
                    if (word_end) begin
                        slot_d = '0;
                        pack_d = '0;
                    end else begin
                        slot_d = slot_q + 1'b1;
                        pack_d = word;
                    end
                    if (is_last) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (tvalid_q && m_tready_i) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
                done_d  = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers; asynchronous reset discards any word in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            addr_q   <= '0;
            slot_q   <= '0;
            pack_q   <= '0;
            tdata_q  <= '0;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            slot_q   <= slot_d;
            pack_q   <= pack_d;
            tdata_q  <= tdata_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            done_q   <= done_d;
        end
    end

    assign busy_o     = (state_q != StIdle);
    assign done_o     = done_q;
    assign lut_addr_o = addr_q;
    assign m_tdata_o  = tdata_q;
    assign m_tvalid_o = tvalid_q;
    assign m_tlast_o  = tlast_q;

endmodule

// File: tb/tb_lut_neuron_table_reader.sv
// Bench for lut_neuron_table_reader: full 8/2/32 sweeps under several
// backpressure patterns plus a small 3/2/32 table on a second instance.
module tb_lut_neuron_table_reader;

    logic        clk;
    logic        rst;

    logic        start;
    logic        busy, done;
    logic [7:0]  lut_addr;
    logic [1:0]  lut_data;
    logic [31:0] m_tdata;
    logic        m_tvalid, m_tready, m_tlast;

    logic        start6;
    logic        busy6, done6;
    logic [2:0]  lut_addr6;
    logic [1:0]  lut_data6;
    logic [31:0] m_tdata6;
    logic        m_tvalid6, m_tready6, m_tlast6;

    int n_vec = 0;
    int n_err = 0;

    // Results of the most recent sweep on the main instance.
    logic [31:0] got_data[$];
    bit          got_last[$];
    int          snap_addr[$];
    logic [31:0] snap_data[$];
    int          first_valid_lat;
    int          done_lat;

    // Neuron stand-ins: combinational truth tables.
    assign lut_data  = lut_addr[1:0] ^ lut_addr[5:4];
    assign lut_data6 = lut_addr6[1:0];

    lut_neuron_table_reader #(
        .IN_BITS(8), .OUT_BITS(2), .WORD_WIDTH(32)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start), .busy_o(busy), .done_o(done),
        .lut_addr_o(lut_addr), .lut_data_i(lut_data), .m_tdata_o(m_tdata),
        .m_tvalid_o(m_tvalid), .m_tready_i(m_tready), .m_tlast_o(m_tlast)
    );

    lut_neuron_table_reader #(
        .IN_BITS(3), .OUT_BITS(2), .WORD_WIDTH(32)
    ) dut6 (
        .clk(clk), .rst(rst), .start_i(start6), .busy_o(busy6), .done_o(done6),
        .lut_addr_o(lut_addr6), .lut_data_i(lut_data6), .m_tdata_o(m_tdata6),
        .m_tvalid_o(m_tvalid6), .m_tready_i(m_tready6), .m_tlast_o(m_tlast6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] f(input int a);
        logic [31:0] v;
        v = a;
        return v[1:0] ^ v[5:4];
    endfunction

    // Word w of a table with 2^in_bits entries, 16 two-bit entries per word.
    function automatic logic [31:0] exp_word(input int w, input int in_bits);
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            if (16 * w + k < (1 << in_bits)) r[2*k +: 2] = f(16 * w + k);
        end
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one sweep. mode 0: always ready, 1: random ready, 2: ready held low
    // for stall_len cycles once the first word is valid. Latencies are the
    // index of the first clock edge after the start edge that samples the signal high.
    task automatic sweep(input int mode, input int stall_len);
        int stall_left;
        got_data.delete();
        got_last.delete();
        snap_addr.delete();
        snap_data.delete();
        first_valid_lat = -1;
        done_lat        = -1;
        stall_left      = stall_len;
        start    = 1'b1;
        m_tready = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 3000 && done_lat < 0; k++) begin
            if (m_tvalid && first_valid_lat < 0) first_valid_lat = k + 1;
            if (done) done_lat = k + 1;
            if (mode == 1) begin
                m_tready = 1'($urandom_range(0, 1));
            end else if (mode == 2 && first_valid_lat >= 0 && stall_left > 0) begin
                m_tready = 1'b0;
                stall_left--;
                snap_addr.push_back(int'(lut_addr));
                snap_data.push_back(m_tdata);
            end else begin
                m_tready = 1'b1;
            end
            if (m_tvalid && m_tready) begin
                got_data.push_back(m_tdata);
                got_last.push_back(m_tlast);
            end
            step();
        end
        m_tready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        start6 = 1'b0;
        m_tready = 1'b1;
        m_tready6 = 1'b1;
        step();
        step();
        n_vec++;
        if ({busy, done, m_tvalid, m_tlast} !== 4'b0) begin
            n_err++;
            $display("FAIL reset_flags got %b want 0000", {busy, done, m_tvalid, m_tlast});
        end
        n_vec++;
        if (lut_addr !== 8'd0 || m_tdata !== 32'd0) begin
            n_err++;
            $display("FAIL reset_regs addr %0d data %h want 0/0", lut_addr, m_tdata);
        end
        rst = 1'b0;
        step();
        // Run into the sweep until word 0 is on the output, then reset mid-cycle.
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 16; i++) step();
        n_vec++;
        if (m_tvalid !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL pre_reset_active valid %b busy %b want 1 1", m_tvalid, busy);
        end
        #3 rst = 1'b1;
        #1;
        n_vec++;
        if ({busy, done, m_tvalid, m_tlast} !== 4'b0) begin
            n_err++;
            $display("FAIL async_reset_flags got %b want 0000", {busy, done, m_tvalid, m_tlast});
        end
        n_vec++;
        if (lut_addr !== 8'd0 || m_tdata !== 32'd0) begin
            n_err++;
            $display("FAIL async_reset_regs addr %0d data %h want 0/0", lut_addr, m_tdata);
        end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_full_sweep();
        sweep(0, 0);
        n_vec++;
        if (first_valid_lat != 17) begin
            n_err++;
            $display("FAIL first_valid_latency got %0d want 17", first_valid_lat);
        end
        n_vec++;
        if (done_lat != 259) begin
            n_err++;
            $display("FAIL done_latency got %0d want 259", done_lat);
        end
        n_vec++;
        if (got_data.size() != 16) begin
            n_err++;
            $display("FAIL sweep_word_count got %0d want 16", got_data.size());
        end
        for (int i = 0; i < got_data.size() && i < 16; i++) begin
            n_vec++;
            if (got_data[i] !== exp_word(i, 8) || got_last[i] !== (i == 15)) begin
                n_err++;
                $display("FAIL sweep_word%0d got %h last %b want %h last %b",
                         i, got_data[i], got_last[i], exp_word(i, 8), (i == 15));
            end
        end
        n_vec++;
        if (busy !== 1'b0 || lut_addr !== 8'd0) begin
            n_err++;
            $display("FAIL sweep_end busy %b addr %0d want 0 0", busy, lut_addr);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        sweep(2, 20);
        n_vec++;
        if (snap_addr.size() != 20) begin
            n_err++;
            $display("FAIL stall_len got %0d want 20", snap_addr.size());
        end
        bad = 0;
        for (int i = 0; i < snap_addr.size(); i++) begin
            if (snap_addr[i] != ((16 + i < 31) ? 16 + i : 31)) bad++;
            if (snap_data[i] !== exp_word(0, 8)) bad++;
        end
        n_vec++;
        if (bad != 0) begin
            n_err++;
            $display("FAIL stall_hold got %0d bad samples want 0 (last addr %0d)",
                     bad, snap_addr.size() > 0 ? snap_addr[snap_addr.size()-1] : -1);
        end
        n_vec++;
        if (got_data.size() != 16) begin
            n_err++;
            $display("FAIL bp_word_count got %0d want 16", got_data.size());
        end
        bad = 0;
        for (int i = 0; i < got_data.size() && i < 16; i++) begin
            if (got_data[i] !== exp_word(i, 8) || got_last[i] !== (i == 15)) bad++;
        end
        n_vec++;
        if (bad != 0 || done_lat < 0) begin
            n_err++;
            $display("FAIL bp_words got %0d bad words done_lat %0d want 0 and done", bad, done_lat);
        end
    endtask

    task automatic test_random_ready();
        int bad;
        int lasts;
        for (int r = 0; r < 2; r++) begin
            sweep(1, 0);
            n_vec++;
            if (got_data.size() != 16 || done_lat < 0) begin
                n_err++;
                $display("FAIL rand_count run %0d got %0d done_lat %0d want 16 and done",
                         r, got_data.size(), done_lat);
            end
            bad = 0;
            lasts = 0;
            for (int i = 0; i < got_data.size(); i++) begin
                if (i >= 16 || got_data[i] !== exp_word(i, 8)) bad++;
                if (got_last[i]) lasts++;
            end
            n_vec++;
            if (bad != 0) begin
                n_err++;
                $display("FAIL rand_data run %0d got %0d bad words want 0", r, bad);
            end
            n_vec++;
            if (lasts != 1 || got_last.size() == 0 || got_last[got_last.size()-1] !== 1'b1) begin
                n_err++;
                $display("FAIL rand_tlast run %0d got %0d lasts want exactly 1 on final word",
                         r, lasts);
            end
        end
    endtask

    task automatic test_restart();
        int guard;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 10; i++) step();
        start = 1'b1;
        step();
        start = 1'b0;
        n_vec++;
        if (lut_addr !== 8'd11 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL start_ignored addr %0d busy %b want 11 1", lut_addr, busy);
        end
        guard = 0;
        while (lut_addr != 8'd100 && guard < 300) begin
            step();
            guard++;
        end
        n_vec++;
        if (lut_addr !== 8'd100) begin
            n_err++;
            $display("FAIL reach_addr100 got %0d want 100", lut_addr);
        end
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if (lut_addr !== 8'd0 || m_tvalid !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL midsweep_reset addr %0d valid %b busy %b want 0 0 0",
                     lut_addr, m_tvalid, busy);
        end
        step();
        rst = 1'b0;
        step();
        sweep(0, 0);
        n_vec++;
        if (got_data.size() != 16 || got_data[0] !== exp_word(0, 8)) begin
            n_err++;
            $display("FAIL restart_word0 count %0d word0 %h want 16 %h", got_data.size(),
                     got_data.size() > 0 ? got_data[0] : 32'hx, exp_word(0, 8));
        end
    endtask

    task automatic test_small_table();
        int cnt;
        bit seen_done;
        logic [31:0] d;
        bit l;
        cnt = 0;
        seen_done = 1'b0;
        d = '0;
        l = 1'b0;
        start6 = 1'b1;
        step();
        start6 = 1'b0;
        for (int k = 0; k < 50 && !seen_done; k++) begin
            if (m_tvalid6 && m_tready6) begin
                cnt++;
                d = m_tdata6;
                l = m_tlast6;
            end
            if (done6) seen_done = 1'b1;
            step();
        end
        n_vec++;
        if (cnt != 1 || !seen_done) begin
            n_err++;
            $display("FAIL small_count got %0d done %b want 1 1", cnt, seen_done);
        end
        n_vec++;
        if (d !== exp_word(0, 3) || l !== 1'b1) begin
            n_err++;
            $display("FAIL small_word got %h last %b want %h last 1", d, l, exp_word(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_full_sweep();
        test_backpressure();
        test_random_ready();
        test_restart();
        test_small_table();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
